// File: rtl/sysid_info_regs.sv
// sysid_info_regs
//   Avalon-MM slave holding system identification and health registers:
//   SYSTEM_ID, build TIMESTAMP, a 64-bit uptime counter (LO/HI with a
//   coherent HI snapshot), SCRATCH, CONTROL (CLEAR/FREEZE) and
//   NUM_USER_WORDS read/write user words. Reads return after a fixed
//   READ_LATENCY with a one-cycle readdatavalid pulse.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   address        word address (ADDR_W bits)
//   read / write   request strobes, accepted every cycle
//   writedata      32-bit write data
//   byteenable     write byte lanes
//   readdata       read data, holds its last value between valids
//   readdatavalid  one-cycle pulse per accepted read

module sysid_info_regs #(
    parameter logic [31:0] SYSTEM_ID      = 32'd29,
    parameter logic [31:0] TIMESTAMP      = 32'd1718188374,
    parameter int          NUM_USER_WORDS = 4,
    parameter int          READ_LATENCY   = 1,
    parameter int          ADDR_W         = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int USER_BASE = 6;

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic [31:0] scratch_q, scratch_d;
    logic        freeze_q, freeze_d;
    logic [31:0] user_q [NUM_USER_WORDS];
    logic [31:0] user_d [NUM_USER_WORDS];

    // Read pipeline. Each data stage only loads when a valid read enters
    // it, so the last stage naturally holds the most recent read result.
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             dat_q [READ_LATENCY];
    logic [31:0]             dat_d [READ_LATENCY];

    logic [31:0] addr_ext;
    logic        rd_acc;
    logic        ctl_wr;
    logic [31:0] rdata_mux;

    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always_comb begin
        addr_ext = 32'(address);
        // A write in the same cycle cancels the read.
        rd_acc   = read && !write;
        // CLEAR and FREEZE both live in byte lane 0.
        ctl_wr   = write && (addr_ext == 32'd5) && byteenable[0];

        rdata_mux = '0;
        case (addr_ext)
            32'd0:   rdata_mux = SYSTEM_ID;
            32'd1:   rdata_mux = TIMESTAMP;
            32'd2:   rdata_mux = cnt_q[31:0];
            32'd3:   rdata_mux = hi_snap_q;
            32'd4:   rdata_mux = scratch_q;
            32'd5:   rdata_mux = {30'd0, freeze_q, 1'b0};
            default: rdata_mux = '0;
        endcase
        for (int i = 0; i < NUM_USER_WORDS; i++)
            if (addr_ext == 32'(USER_BASE + i)) rdata_mux = user_q[i];

        // Counter: CLEAR beats both increment and FREEZE.
        if (ctl_wr && writedata[0])
            cnt_d = '0;
        else if (!freeze_q)
            cnt_d = cnt_q + 64'd1;
        else
            cnt_d = cnt_q;

        freeze_d = ctl_wr ? writedata[1] : freeze_q;

        // Reading LO captures the upper word that belongs with it, so a
        // later HI read is coherent even across a carry into bit 32.
        hi_snap_d = (rd_acc && addr_ext == 32'd2) ? cnt_q[63:32] : hi_snap_q;

        scratch_d = (write && addr_ext == 32'd4)
                    ? be_merge(scratch_q, writedata, byteenable) : scratch_q;

        for (int i = 0; i < NUM_USER_WORDS; i++) begin
            user_d[i] = user_q[i];
            if (write && addr_ext == 32'(USER_BASE + i))
                user_d[i] = be_merge(user_q[i], writedata, byteenable);
        end

        vld_d[0] = rd_acc;
        dat_d[0] = rd_acc ? rdata_mux : dat_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_snap_q <= '0;
            scratch_q <= '0;
            freeze_q  <= 1'b0;
            user_q    <= '{default: '0};
            vld_q     <= '0;
            dat_q     <= '{default: '0};
        end else begin
            cnt_q     <= cnt_d;
            hi_snap_q <= hi_snap_d;
            scratch_q <= scratch_d;
            freeze_q  <= freeze_d;
            user_q    <= user_d;
            vld_q     <= vld_d;
            dat_q     <= dat_d;
        end
    end

    assign readdata      = dat_q[READ_LATENCY-1];
    assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_info_regs.sv
module tb_sysid_info_regs;

    localparam int NU = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] rd1, rd3;
    logic        rdv1, rdv3;

    always #5 clock = ~clock;

    sysid_info_regs #(.NUM_USER_WORDS(NU), .READ_LATENCY(1), .ADDR_W(4)) u_lat1 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rd1), .readdatavalid(rdv1));

    sysid_info_regs #(.NUM_USER_WORDS(NU), .READ_LATENCY(3), .ADDR_W(4)) u_lat3 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rd3), .readdatavalid(rdv3));

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Reference model: architectural state plus queues of pending responses.
    typedef struct { int due; logic [31:0] d; } resp_t;
    resp_t       q1[$];
    resp_t       q3[$];
    logic [31:0] last1, last3;
    logic [63:0] m_cnt;
    logic [31:0] m_hi, m_scr;
    logic        m_frz;
    logic [31:0] m_user [NU];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (cur & ~m) | (wd & m);
    endfunction

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0: return 32'd29;
            1: return 32'd1718188374;
            2: return m_cnt[31:0];
            3: return m_hi;
            4: return m_scr;
            5: return {30'd0, m_frz, 1'b0};
            default: return (a >= 6 && a < 6 + NU) ? m_user[a-6] : 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        int a;
        logic [31:0] v;
        logic ctl;
        edge_n++;
        a = int'(address);
        if (reset) begin
            m_cnt = '0; m_hi = '0; m_scr = '0; m_frz = 1'b0;
            for (int i = 0; i < NU; i++) m_user[i] = '0;
            q1.delete(); q3.delete();
            last1 = '0; last3 = '0;
        end else begin
            if (read && !write) begin
                v = model_read(a);
                if (a == 2) m_hi = m_cnt[63:32];
                q1.push_back('{edge_n, v});
                q3.push_back('{edge_n + 2, v});
            end
            ctl = write && a == 5 && byteenable[0];
            if (ctl && writedata[0]) m_cnt = '0;
            else if (!m_frz) m_cnt = m_cnt + 64'd1;
            if (ctl) m_frz = writedata[1];
            if (write && a == 4) m_scr = merge(m_scr, writedata, byteenable);
            if (write && a >= 6 && a < 6 + NU) m_user[a-6] = merge(m_user[a-6], writedata, byteenable);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        resp_t r;
        ev = 1'b0;
        if (q1.size() > 0 && q1[0].due == edge_n) begin r = q1.pop_front(); ev = 1'b1; last1 = r.d; end
        chk("rdv_lat1", {63'd0, rdv1}, {63'd0, ev});
        chk("rd_lat1", {32'd0, rd1}, {32'd0, last1});
        ev = 1'b0;
        if (q3.size() > 0 && q3[0].due == edge_n) begin r = q3.pop_front(); ev = 1'b1; last3 = r.d; end
        chk("rdv_lat3", {63'd0, rdv3}, {63'd0, ev});
        chk("rd_lat3", {32'd0, rd3}, {32'd0, last3});
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
        step();
        write = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d,
                           output int lat1, output int lat3);
        lat1 = -1; lat3 = -1; d = 'x;
        address = a; read = 1'b1; write = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            read = 1'b0;
            if (rdv1 && lat1 < 0) begin lat1 = k; d = rd1; end
            if (rdv3 && lat3 < 0) lat3 = k;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] d, v1, v2;
        int l1, l3;

        vecs[0] = '{1'b0, 4'd0,  32'h0,        4'h0, 32'd29};
        vecs[1] = '{1'b0, 4'd1,  32'h0,        4'h0, 32'd1718188374};
        vecs[2] = '{1'b1, 4'd4,  32'hDEADBEEF, 4'b0101, 32'h00AD00EF};
        vecs[3] = '{1'b1, 4'd4,  32'hFFFFFFFF, 4'b1000, 32'hFFAD00EF};
        vecs[4] = '{1'b0, 4'd12, 32'h0,        4'h0, 32'h0};
        vecs[5] = '{1'b1, 4'd6,  32'hA5A5A5A5, 4'b1111, 32'hA5A5A5A5};
        vecs[6] = '{1'b1, 4'd9,  32'h12345678, 4'b0011, 32'h00005678};
        vecs[7] = '{1'b1, 4'd10, 32'hFFFFFFFF, 4'b1111, 32'h0};
        vecs[8] = '{1'b1, 4'd5,  32'hFFFFFFFC, 4'b1111, 32'h0};
        vecs[9] = '{1'b0, 4'd15, 32'h0,        4'h0, 32'h0};

        // Reset, then outputs must be zero.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset_rdv1", {63'd0, rdv1}, 64'd0);
        chk("reset_rd1", {32'd0, rd1}, 64'd0);

        // Latency of ID reads.
        do_read(4'd0, d, l1, l3);
        chk("lat1_cycles", 64'(l1), 64'd1);
        chk("lat3_cycles", 64'(l3), 64'd3);

        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            do_read(vecs[i].addr, d, l1, l3);
            chk($sformatf("vec%0d", i), {32'd0, d}, {32'd0, vecs[i].exp});
        end

        // Coherent HI snapshot across a carry into bit 32.
        do_write(4'd5, 32'd2, 4'hF);
        force u_lat1.cnt_q = 64'h0000_0000_FFFF_FFFE;
        force u_lat3.cnt_q = 64'h0000_0000_FFFF_FFFE;
        step();
        release u_lat1.cnt_q;
        release u_lat3.cnt_q;
        m_cnt = 64'h0000_0000_FFFF_FFFE;
        do_write(4'd5, 32'd0, 4'hF);
        do_read(4'd2, d, l1, l3);
        chk("lo_before_carry", {32'd0, d}, 64'hFFFF_FFFE);
        do_read(4'd3, d, l1, l3);
        chk("hi_snapshot", {32'd0, d}, 64'd0);
        do_read(4'd2, d, l1, l3);
        do_read(4'd3, d, l1, l3);
        chk("hi_after_carry", {32'd0, d}, 64'd1);

        // FREEZE holds the count; CLEAR restarts from zero.
        do_write(4'd5, 32'd2, 4'hF);
        do_read(4'd2, v1, l1, l3);
        repeat (10) step();
        do_read(4'd2, v2, l1, l3);
        chk("freeze_hold", {32'd0, v2}, {32'd0, v1});
        do_write(4'd5, 32'd1, 4'hF);
        do_read(4'd2, d, l1, l3);
        chk("clear_lo0", {32'd0, d}, 64'd0);
        do_read(4'd2, d, l1, l3);
        chk("clear_count6", {32'd0, d}, 64'd6);
        do_read(4'd5, d, l1, l3);
        chk("control_read", {32'd0, d}, 64'd0);

        // CLEAR and FREEZE together: zero and held.
        do_write(4'd5, 32'd3, 4'hF);
        do_read(4'd2, d, l1, l3);
        chk("clrfrz_a", {32'd0, d}, 64'd0);
        do_read(4'd2, d, l1, l3);
        chk("clrfrz_b", {32'd0, d}, 64'd0);
        do_write(4'd5, 32'd0, 4'hF);

        // Read + write together: write wins, no valid.
        address = 4'd6; writedata = 32'h12345678; byteenable = 4'hF;
        read = 1'b1; write = 1'b1;
        step();
        read = 1'b0; write = 1'b0;
        chk("rdwr_no_valid", {63'd0, rdv1}, 64'd0);
        do_read(4'd6, d, l1, l3);
        chk("rdwr_data", {32'd0, d}, 64'h12345678);

        // Reset while latency-3 reads are in flight.
        address = 4'd1; read = 1'b1;
        step(); step(); step();
        read = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("inflight_rdv3", {63'd0, rdv3}, 64'd0);
        chk("inflight_rd3", {32'd0, rd3}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("inflight_quiet", {63'd0, rdv3}, 64'd0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            address    = 4'($urandom_range(0, 15));
            read       = ($urandom_range(0, 2) != 0);
            write      = ($urandom_range(0, 3) == 0);
            writedata  = $urandom;
            byteenable = 4'($urandom_range(0, 15));
            step();
        end
        reset = 1'b0; read = 1'b0; write = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
